// File: rtl/mem_arb_types.sv
// Shared types for the memory arbiter: FSM state encoding and port-index sizing helper.
package mem_arb_types;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_arb_state_t;

  // Port index width; a two-port arbiter still needs one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_select.sv
// arb_select: combinational rotating priority encoder. Returns the first requesting
// port found when searching upward from start (wrapping), plus a valid bit.
module arb_select #(
  parameter int NUM_PORTS = 2,
  parameter int IDXW      = 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDXW-1:0]      start,
  output logic [IDXW-1:0]      idx,
  output logic                 valid
);

  localparam logic [IDXW:0] N_W = (IDXW+1)'(NUM_PORTS);

  logic [2*NUM_PORTS-1:0] dbl_shift;
  logic [NUM_PORTS-1:0]   rot;
  logic [NUM_PORTS-1:0]   lowest;
  logic [IDXW-1:0]        off_chain [NUM_PORTS+1];
  logic [IDXW:0]          sum;
  logic [IDXW:0]          wrapped;

  // Rotate so that bit 0 is the port at start, then isolate the lowest set bit.
  assign dbl_shift = {req, req} >> start;
  assign rot       = dbl_shift[NUM_PORTS-1:0];
  assign lowest    = rot & (~rot + NUM_PORTS'(1));

  assign off_chain[0] = '0;
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_enc
      assign off_chain[gi+1] = off_chain[gi] | (lowest[gi] ? IDXW'(gi) : '0);
    end
  endgenerate

  assign sum     = {1'b0, start} + {1'b0, off_chain[NUM_PORTS]};
  assign wrapped = sum - N_W;
  assign idx     = (sum >= N_W) ? wrapped[IDXW-1:0] : sum[IDXW-1:0];
  assign valid   = |req;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: N-port to single-port memory arbiter, IDLE/BUSY handshake.
// Define MEM_ARB_RR_EN for round-robin grant; default build is fixed priority (port 0 highest).
module mem_arbiter
  import mem_arb_types::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int BE_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_PORTS-1:0]                  req_read,
  input  logic [NUM_PORTS-1:0]                  req_write,
  input  logic [NUM_PORTS-1:0][BE_WIDTH-1:0]    req_byte_enable,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  req_address,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]                  req_resp,
  output logic [DATA_WIDTH-1:0]                 req_rdata,
  output logic                                  mem_read,
  output logic                                  mem_write,
  output logic [BE_WIDTH-1:0]                   mem_byte_enable,
  output logic [ADDR_WIDTH-1:0]                 mem_address,
  output logic [DATA_WIDTH-1:0]                 mem_wdata,
  input  logic                                  mem_resp,
  input  logic [DATA_WIDTH-1:0]                 mem_rdata
);

  localparam int IDXW = idx_width(NUM_PORTS);

  mem_arb_state_t        state_reg;
  logic [IDXW-1:0]       grant_reg;
  logic                  write_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [BE_WIDTH-1:0]   be_reg;

  logic [NUM_PORTS-1:0]  req_any;
  logic [IDXW-1:0]       sel_idx;
  logic                  sel_valid;
  logic [IDXW-1:0]       start_ptr;
  logic                  sel_write;
  logic                  busy;
  logic                  resp_fire;

  assign req_any = req_read | req_write;

`ifdef MEM_ARB_RR_EN
  logic [IDXW-1:0] ptr_reg;
  logic [IDXW-1:0] ptr_next;

  assign start_ptr = ptr_reg;
  assign ptr_next  = (sel_idx == IDXW'(NUM_PORTS - 1)) ? '0 : sel_idx + IDXW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (state_reg == IDLE && sel_valid) begin
      ptr_reg <= ptr_next;
    end
  end
`else
  assign start_ptr = '0;
`endif

  arb_select #(
    .NUM_PORTS(NUM_PORTS),
    .IDXW     (IDXW)
  ) u_arb_select (
    .req  (req_any),
    .start(start_ptr),
    .idx  (sel_idx),
    .valid(sel_valid)
  );

  // A port raising both read and write is served as a write.
  assign sel_write = req_write[sel_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      write_reg <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      be_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (sel_valid) begin
            state_reg <= BUSY;
            grant_reg <= sel_idx;
            write_reg <= sel_write;
            addr_reg  <= req_address[sel_idx];
            wdata_reg <= sel_write ? req_wdata[sel_idx] : '0;
            be_reg    <= sel_write ? req_byte_enable[sel_idx] : '1;
          end
        end
        BUSY: begin
          if (mem_resp) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy      = (state_reg == BUSY);
  // A reset coinciding with completion drops the transaction without a pulse.
  assign resp_fire = busy && mem_resp && !rst;

  assign mem_read        = busy && !write_reg;
  assign mem_write       = busy && write_reg;
  assign mem_address     = busy ? addr_reg  : '0;
  assign mem_wdata       = busy ? wdata_reg : '0;
  assign mem_byte_enable = busy ? be_reg    : '0;
  assign req_rdata       = resp_fire ? mem_rdata : '0;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_resp
      assign req_resp[gi] = resp_fire && (grant_reg == IDXW'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (default fixed-priority build): per-cycle vector table
// plus a hand-written write-with-stall sequence.
module tb_mem_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_read, req_write;
  logic [1:0][3:0]  req_byte_enable;
  logic [1:0][31:0] req_address, req_wdata;
  logic [1:0]       req_resp;
  logic [31:0]      req_rdata;
  logic             mem_read, mem_write;
  logic [3:0]       mem_byte_enable;
  logic [31:0]      mem_address, mem_wdata;
  logic             mem_resp;
  logic [31:0]      mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_read(req_read), .req_write(req_write), .req_byte_enable(req_byte_enable),
    .req_address(req_address), .req_wdata(req_wdata),
    .req_resp(req_resp), .req_rdata(req_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic        mresp;
    logic [31:0] mrdata;
    logic [1:0]  e_resp;
    logic [31:0] e_rdata;
    logic        e_mrd;
    logic        e_mwr;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [1:0] rd, input logic [1:0] wr,
                     input logic mresp, input logic [31:0] mrdata,
                     input logic [1:0] e_resp, input logic [31:0] e_rdata,
                     input logic e_mrd, input logic e_mwr, input logic [31:0] e_addr,
                     input logic [3:0] e_be, input logic [31:0] e_wdata);
    vec_t v;
    v.rst = r; v.rd = rd; v.wr = wr; v.mresp = mresp; v.mrdata = mrdata;
    v.e_resp = e_resp; v.e_rdata = e_rdata; v.e_mrd = e_mrd; v.e_mwr = e_mwr;
    v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (step %0d): got %h, want %h", name, id, act, exp);
    end
  endtask

  task automatic check_all(input int id, input vec_t v);
    chk("req_resp",        id, 32'(req_resp),        32'(v.e_resp));
    chk("req_rdata",       id, req_rdata,            v.e_rdata);
    chk("mem_read",        id, 32'(mem_read),        32'(v.e_mrd));
    chk("mem_write",       id, 32'(mem_write),       32'(v.e_mwr));
    chk("mem_address",     id, mem_address,          v.e_addr);
    chk("mem_byte_enable", id, 32'(mem_byte_enable), 32'(v.e_be));
    chk("mem_wdata",       id, mem_wdata,            v.e_wdata);
  endtask

  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] A1 = 32'h0000_0040;
  localparam logic [31:0] W0 = 32'h1234_5678;
  localparam logic [31:0] W1 = 32'hAAAA_5555;

  initial begin
    vec_t idle_v;
    int   wait_cyc;
    bit   seen;

    rst = 1'b1; req_read = '0; req_write = '0; mem_resp = 1'b0; mem_rdata = '0;
    req_address[0] = A0;  req_address[1] = A1;
    req_wdata[0]   = W0;  req_wdata[1]   = W1;
    req_byte_enable[0] = 4'b0011; req_byte_enable[1] = 4'b1100;

    //   rst rd     wr     mr  mrdata        resp   rdata         rd wr addr be       wdata
    // single-port read on port 1, response after 3 busy cycles
    add(0, 2'b10, 2'b00, 0, 32'h0,        2'b00, 32'h0,        0, 0, 0,  4'h0,    0);
    add(0, 2'b10, 2'b00, 0, 32'h0,        2'b00, 32'h0,        1, 0, A1, 4'hF,    0);
    add(0, 2'b10, 2'b00, 0, 32'h0,        2'b00, 32'h0,        1, 0, A1, 4'hF,    0);
    add(0, 2'b10, 2'b00, 1, 32'hDEADBEEF, 2'b10, 32'hDEADBEEF, 1, 0, A1, 4'hF,    0);
    add(0, 2'b00, 2'b00, 0, 32'hDEADBEEF, 2'b00, 32'h0,        0, 0, 0,  4'h0,    0);
    // write from port 0 with partial byte enables
    add(0, 2'b00, 2'b01, 0, 32'h0,        2'b00, 32'h0,        0, 0, 0,  4'h0,    0);
    add(0, 2'b00, 2'b01, 0, 32'h0,        2'b00, 32'h0,        0, 1, A0, 4'b0011, W0);
    add(0, 2'b00, 2'b01, 1, 32'hFFFF0000, 2'b01, 32'hFFFF0000, 0, 1, A0, 4'b0011, W0);
    add(0, 2'b00, 2'b00, 0, 32'h0,        2'b00, 32'h0,        0, 0, 0,  4'h0,    0);
    // contention: port 0 first, port 1 on the following IDLE cycle
    add(0, 2'b11, 2'b00, 0, 32'h0,        2'b00, 32'h0,        0, 0, 0,  4'h0,    0);
    add(0, 2'b11, 2'b00, 1, 32'h11111111, 2'b01, 32'h11111111, 1, 0, A0, 4'hF,    0);
    add(0, 2'b10, 2'b00, 0, 32'h0,        2'b00, 32'h0,        0, 0, 0,  4'h0,    0);
    add(0, 2'b10, 2'b00, 1, 32'h22222222, 2'b10, 32'h22222222, 1, 0, A1, 4'hF,    0);
    add(0, 2'b00, 2'b00, 0, 32'h0,        2'b00, 32'h0,        0, 0, 0,  4'h0,    0);
    // read and write together on one port is a write
    add(0, 2'b01, 2'b01, 0, 32'h0,        2'b00, 32'h0,        0, 0, 0,  4'h0,    0);
    add(0, 2'b01, 2'b01, 1, 32'h00000033, 2'b01, 32'h00000033, 0, 1, A0, 4'b0011, W0);
    add(0, 2'b00, 2'b00, 0, 32'h0,        2'b00, 32'h0,        0, 0, 0,  4'h0,    0);
    // request dropped while busy still completes, single pulse
    add(0, 2'b01, 2'b00, 0, 32'h0,        2'b00, 32'h0,        0, 0, 0,  4'h0,    0);
    add(0, 2'b00, 2'b00, 0, 32'h0,        2'b00, 32'h0,        1, 0, A0, 4'hF,    0);
    add(0, 2'b00, 2'b00, 1, 32'h00000044, 2'b01, 32'h00000044, 1, 0, A0, 4'hF,    0);
    add(0, 2'b00, 2'b00, 0, 32'h0,        2'b00, 32'h0,        0, 0, 0,  4'h0,    0);
    // stray mem_resp while idle is ignored
    add(0, 2'b00, 2'b00, 1, 32'h00000055, 2'b00, 32'h0,        0, 0, 0,  4'h0,    0);
    // reset in the second busy cycle drops the transaction
    add(0, 2'b10, 2'b00, 0, 32'h0,        2'b00, 32'h0,        0, 0, 0,  4'h0,    0);
    add(0, 2'b10, 2'b00, 0, 32'h0,        2'b00, 32'h0,        1, 0, A1, 4'hF,    0);
    add(1, 2'b10, 2'b00, 0, 32'h0,        2'b00, 32'h0,        1, 0, A1, 4'hF,    0);
    add(0, 2'b10, 2'b00, 1, 32'h00000066, 2'b00, 32'h0,        0, 0, 0,  4'h0,    0);
    add(0, 2'b10, 2'b00, 1, 32'h00000077, 2'b10, 32'h00000077, 1, 0, A1, 4'hF,    0);
    add(0, 2'b00, 2'b00, 0, 32'h0,        2'b00, 32'h0,        0, 0, 0,  4'h0,    0);
    // reset coinciding with mem_resp gives no pulse
    add(0, 2'b01, 2'b00, 0, 32'h0,        2'b00, 32'h0,        0, 0, 0,  4'h0,    0);
    add(1, 2'b01, 2'b00, 1, 32'h00000088, 2'b00, 32'h0,        1, 0, A0, 4'hF,    0);
    add(0, 2'b00, 2'b00, 0, 32'h0,        2'b00, 32'h0,        0, 0, 0,  4'h0,    0);

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #2;
    idle_v = vecs[0];
    idle_v.rd = '0;
    check_all(-1, idle_v);
    $display("step -1: reset state checked");

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; req_read = vecs[i].rd; req_write = vecs[i].wr;
      mem_resp = vecs[i].mresp; mem_rdata = vecs[i].mrdata;
      #2;
      check_all(i, vecs[i]);
      $display("step %0d: rst=%b rd=%b wr=%b mresp=%b -> resp=%b rdata=%h mrd=%b mwr=%b addr=%h",
               i, rst, req_read, req_write, mem_resp, req_resp, req_rdata, mem_read, mem_write, mem_address);
    end

    // port 1 write held through a long stall; outputs must stay stable
    @(negedge clk);
    rst = 1'b0; req_read = '0; req_write = 2'b10; mem_resp = 1'b0; mem_rdata = '0;
    seen = 1'b0; wait_cyc = 0;
    for (int c = 1; c <= 4 && !seen; c++) begin
      @(negedge clk); #2;
      if (mem_write) begin seen = 1'b1; wait_cyc = c; end
    end
    chk("stall_write_latency", 100, 32'(wait_cyc), 32'd1);
    for (int s = 0; s < 5; s++) begin
      chk("stall_mem_write", 101 + s, 32'(mem_write), 32'd1);
      chk("stall_mem_address", 101 + s, mem_address, A1);
      chk("stall_mem_wdata", 101 + s, mem_wdata, W1);
      chk("stall_mem_be", 101 + s, 32'(mem_byte_enable), 32'hC);
      chk("stall_req_resp", 101 + s, 32'(req_resp), 32'd0);
      @(negedge clk); #2;
    end
    mem_resp = 1'b1; mem_rdata = 32'h0000_00AB;
    #1;
    chk("stall_resp", 110, 32'(req_resp), 32'b10);
    chk("stall_rdata", 110, req_rdata, 32'h0000_00AB);
    $display("stall sequence: write port 1 latency=%0d resp=%b", wait_cyc, req_resp);
    @(negedge clk);
    req_write = '0; mem_resp = 1'b0;
    #2;
    chk("stall_after_write", 111, 32'(mem_write), 32'd0);
    chk("stall_after_resp", 111, 32'(req_resp), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of requesters; legal range 2..8.
REQ-002 Parameter ADDR_WIDTH, default 32: address width.
REQ-003 Parameter DATA_WIDTH, default 32: data width; multiple of 8; BE_WIDTH = DATA_WIDTH/8.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 req_read  input  [NUM_PORTS]  per-port read request; held until that port's req_resp.
REQ-007 req_write  input  [NUM_PORTS]  per-port write request; held until that port's req_resp.
REQ-008 req_byte_enable  input  [NUM_PORTS][BE_WIDTH]  per-port write byte enables.
REQ-009 req_address  input  [NUM_PORTS][ADDR_WIDTH]  per-port address.
REQ-010 req_wdata  input  [NUM_PORTS][DATA_WIDTH]  per-port write data.
REQ-011 req_resp  output  [NUM_PORTS]  one-cycle completion pulse to the granted port only.
REQ-012 req_rdata  output  [DATA_WIDTH]  read data, shared by all ports; valid while any req_resp bit is 1.
REQ-013 mem_read  output  1  downstream read strobe.
REQ-014 mem_write  output  1  downstream write strobe.
REQ-015 mem_byte_enable  output  [BE_WIDTH]  downstream byte enables.
REQ-016 mem_address  output  [ADDR_WIDTH]  downstream address.
REQ-017 mem_wdata  output  [DATA_WIDTH]  downstream write data.
REQ-018 mem_resp  input  1  downstream completion; one cycle; ends the current transaction.
REQ-019 mem_rdata  input  [DATA_WIDTH]  downstream read data; valid with mem_resp.

Function
REQ-020 FSM SHALL have two states: IDLE and BUSY.
REQ-021 IDLE, no port requesting: stay IDLE; mem_read = mem_write = 0.
REQ-022 IDLE, any port requesting: select one grant port (REQ-029); register its op, address, wdata and byte_enable; go to BUSY next cycle.
REQ-023 BUSY SHALL drive mem_* from the registered values, so mem_read or mem_write asserts exactly one cycle after the request is first seen in IDLE.
REQ-024 BUSY, mem_resp = 0: stay BUSY; mem_* outputs stable.
REQ-025 BUSY, mem_resp = 1, same cycle: req_resp[grant] = 1 and req_rdata = mem_rdata; next state IDLE with mem_read = mem_write = 0.
REQ-026 When req_read and req_write are both asserted on one port, the port SHALL be treated as a write.
REQ-027 A request dropped during BUSY SHALL NOT abort the transaction; completion and the req_resp pulse still occur.
REQ-028 Outside completion: req_resp = 0 and req_rdata = 0. For read ops: mem_byte_enable = all ones and mem_wdata = 0.
REQ-029 Grant SHALL be fixed priority, lowest port index wins, unless MEM_ARB_RR_EN is defined (REQ-033).
REQ-030 The grant SHALL NOT change while in BUSY.

Reset
REQ-031 With rst = 1 at a clock edge: state = IDLE, all outputs = 0, round-robin pointer = 0.
REQ-032 Reset during BUSY SHALL drop the transaction with no req_resp pulse; the downstream memory is reset in the same cycle.

Configuration
REQ-033 Macro MEM_ARB_RR_EN defined: round-robin arbitration; search starts at pointer p; after a grant to port i, p = (i+1) mod NUM_PORTS.
REQ-034 MEM_ARB_RR_EN undefined: fixed priority per REQ-029; no pointer register exists.

Structure
REQ-035 Enum mem_arb_state_t (IDLE, BUSY) SHALL live in shared package mem_arb_types, alongside rv32i_types.
REQ-036 Grant selection SHALL be sub-module arb_select: combinational priority encoder over a request vector plus start pointer, returning a port index and a valid bit.

Verification
REQ-037 Single port: port 1 reads 0x0000_0040; mem_resp after 3 cycles with mem_rdata 0xDEAD_BEEF -> mem_read rises 1 cycle after request; req_resp = 2'b10 and req_rdata = 0xDEAD_BEEF for exactly one cycle.
REQ-038 Contention, fixed priority: ports 0 and 1 request in the same cycle -> port 0 served first; port 1 served on the next IDLE cycle.
REQ-039 Contention, MEM_ARB_RR_EN: both ports request continuously over 4 transactions -> grant order 0,1,0,1.
REQ-040 Write: port 0 writes 0x1234_5678 with byte_enable 4'b0011 to 0x0000_0100 -> mem_write = 1 with mem_wdata, mem_byte_enable and mem_address matching, held until mem_resp.
REQ-041 Reset mid-op: assert rst in the 2nd BUSY cycle -> next cycle all outputs 0, no req_resp pulse; FSM in IDLE.
REQ-042 Dropped request: port 0 deasserts req_read while BUSY -> transaction still completes and req_resp[0] pulses once.
